// File: rtl/osd_overlay_pkg.sv
// osd_overlay_pkg -- shared definitions for the OSD overlay mixer.
//   RGB565 field positions, pipeline latency, bitmap default depth,
//   pixel-index width helper and the RGB565 -> RGB888 expansion.
package osd_overlay_pkg;

  localparam int LATENCY           = 3;
  localparam int OSD_MEM_WORDS_DEF = 4096;

  localparam int R5_MSB = 15;
  localparam int R5_LSB = 11;
  localparam int G6_MSB = 10;
  localparam int G6_LSB = 5;
  localparam int B5_MSB = 4;
  localparam int B5_LSB = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Width of a pixel index into a bitmap of 'words' 32-bit words (2 px each).
  function automatic int pix_idx_w(input int words);
    return $clog2(2 * words);
  endfunction

  // Replicate the top bits into the LSBs so full-scale 565 maps to 8'hFF.
  function automatic rgb888_t rgb565_expand(input logic [15:0] px);
    rgb888_t c;
    c.r = {px[R5_MSB:R5_LSB], px[R5_MSB -: 3]};
    c.g = {px[G6_MSB:G6_LSB], px[G6_MSB -: 2]};
    c.b = {px[B5_MSB:B5_LSB], px[B5_MSB -: 3]};
    return c;
  endfunction

endpackage

// File: rtl/osd_pixel_ram.sv
// osd_pixel_ram -- bitmap store: writes one 32-bit word (two pixels) per
// cycle, reads one 16-bit pixel per cycle with a registered output.
//   clk   : clock
//   we    : write enable (address already range-checked by the caller)
//   waddr : word address
//   wdata : pixel 2*waddr in [15:0], pixel 2*waddr+1 in [31:16]
//   raddr : pixel index
//   rdata : pixel read, valid one cycle after raddr
// Read-during-write of the same pixel returns the old contents.
module osd_pixel_ram
  import osd_overlay_pkg::*;
#(
  parameter int WORDS = OSD_MEM_WORDS_DEF,
  parameter int IDX_W = pix_idx_w(OSD_MEM_WORDS_DEF)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-2:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [15:0]      rdata
);

  // Even and odd pixels live in separate banks so one word write hits both.
  logic [15:0] even_mem [WORDS];
  logic [15:0] odd_mem  [WORDS];
  logic [15:0] even_q_r;
  logic [15:0] odd_q_r;
  logic        odd_sel_r;

  // Word write into both banks.
  always_ff @(posedge clk) begin
    if (we) begin
      even_mem[waddr] <= wdata[15:0];
      odd_mem[waddr]  <= wdata[31:16];
    end
  end

  // Registered read of both banks plus the bank select.
  always_ff @(posedge clk) begin
    even_q_r  <= even_mem[raddr[IDX_W-1:1]];
    odd_q_r   <= odd_mem[raddr[IDX_W-1:1]];
    odd_sel_r <= raddr[0];
  end

  assign rdata = odd_sel_r ? odd_q_r : even_q_r;

endmodule

// File: rtl/osd_overlay.sv
// osd_overlay -- inline on-screen-display mixer for a multi-pixel-per-clock
// RGB stream. Pixels inside a programmable window are replaced (or 50%
// blended) with RGB565 bitmap pixels. Latency is 3 cycles for timing and
// pixels regardless of enable.
//   vid_clk_i / vid_rst_i      : clock, synchronous active-high reset
//   vs_i hs_i de_i / *_o       : timing in / delayed timing out
//   r_i g_i b_i / r_o g_o b_o  : pixel p at [p*BPC +: BPC], p=0 leftmost
//   osd_enable_i               : overlay on
//   osd_transparent_i          : blend instead of replace
//   osd_ports_i                : active pixels per clock (0->1, clamped)
//   osd_x_i osd_y_i osd_h_i osd_v_i : window origin and size
//   osd_waddr_i osd_wdata_i osd_wreq_i : bitmap word write port
// Build option: define OSD_COLORKEY_EN to treat bitmap pixel 16'h0000 as
// transparent (video shown).
module osd_overlay
  import osd_overlay_pkg::*;
#(
  parameter int MAX_PORTS     = 2,
  parameter int BPC           = 8,
  parameter int OSD_MEM_WORDS = OSD_MEM_WORDS_DEF
) (
  input  logic                     vid_clk_i,
  input  logic                     vid_rst_i,
  input  logic                     vs_i,
  input  logic                     hs_i,
  input  logic                     de_i,
  input  logic [BPC*MAX_PORTS-1:0] r_i,
  input  logic [BPC*MAX_PORTS-1:0] g_i,
  input  logic [BPC*MAX_PORTS-1:0] b_i,
  output logic                     vs_o,
  output logic                     hs_o,
  output logic                     de_o,
  output logic [BPC*MAX_PORTS-1:0] r_o,
  output logic [BPC*MAX_PORTS-1:0] g_o,
  output logic [BPC*MAX_PORTS-1:0] b_o,
  input  logic                     osd_enable_i,
  input  logic                     osd_transparent_i,
  input  logic [2:0]               osd_ports_i,
  input  logic [15:0]              osd_x_i,
  input  logic [15:0]              osd_y_i,
  input  logic [15:0]              osd_h_i,
  input  logic [15:0]              osd_v_i,
  input  logic [15:0]              osd_waddr_i,
  input  logic [31:0]              osd_wdata_i,
  input  logic                     osd_wreq_i
);

  localparam int PW    = BPC * MAX_PORTS;
  localparam int IDX_W = pix_idx_w(OSD_MEM_WORDS);

  // MSB-aligned resize of an 8-bit component to BPC bits.
  function automatic logic [BPC-1:0] to_bpc(input logic [7:0] c8);
    logic [BPC-1:0] o;
    o = {BPC{1'b0}};
    for (int i = 0; i < 8; i++) begin
      if (i < BPC) o[BPC-1-i] = c8[7-i];
    end
    return o;
  endfunction

  // Average with a 9-bit intermediate sum, truncated.
  function automatic logic [BPC-1:0] blend(input logic [BPC-1:0] a, input logic [BPC-1:0] b);
    logic [BPC:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BPC:1];
  endfunction

  logic [2:0]           ports_eff_s;
  logic                 wr_en_s;
  logic [15:0]          col_r, row_r;
  logic [31:0]          line_base_r;
  logic                 de_prev_r, vs_prev_r;
  logic [16:0]          win_x_end_s, win_y_end_s;
  logic                 win_ok_s, row_in_win_s;
  logic [MAX_PORTS-1:0] hit_s, hit1_r, hit2_r;
  logic [IDX_W-1:0]     idx_s  [MAX_PORTS];
  logic [IDX_W-1:0]     idx1_r [MAX_PORTS];
  logic [15:0]          ram_q_s [MAX_PORTS];
  logic                 transp1_r, transp2_r;
  logic [PW-1:0]        r1_r, g1_r, b1_r, r2_r, g2_r, b2_r;
  logic [PW-1:0]        mix_r_s, mix_g_s, mix_b_s;
  logic [LATENCY-1:0]   vs_dly_r, hs_dly_r, de_dly_r;

  // Effective ports: 0 counts as 1, anything above MAX_PORTS clamps.
  always_comb begin
    ports_eff_s = 3'd1;
    if (osd_ports_i == 3'd0) begin
      ports_eff_s = 3'd1;
    end else if (int'(osd_ports_i) > MAX_PORTS) begin
      ports_eff_s = 3'(MAX_PORTS);
    end else begin
      ports_eff_s = osd_ports_i;
    end
  end

  assign wr_en_s      = osd_wreq_i && (int'(osd_waddr_i) < OSD_MEM_WORDS);
  assign win_x_end_s  = {1'b0, osd_x_i} + {1'b0, osd_h_i};
  assign win_y_end_s  = {1'b0, osd_y_i} + {1'b0, osd_v_i};
  assign win_ok_s     = (osd_h_i != 16'd0) && (osd_v_i != 16'd0);
  assign row_in_win_s = ({1'b0, row_r} >= {1'b0, osd_y_i}) && ({1'b0, row_r} < win_y_end_s);

  // Raster position; line base grows by H for each windowed line so the
  // pixel index needs no multiplier.
  always_ff @(posedge vid_clk_i) begin
    if (vid_rst_i) begin
      col_r       <= 16'd0;
      row_r       <= 16'd0;
      line_base_r <= 32'd0;
      de_prev_r   <= 1'b0;
      vs_prev_r   <= 1'b0;
    end else begin
      col_r     <= de_i ? (col_r + {13'd0, ports_eff_s}) : 16'd0;
      de_prev_r <= de_i;
      vs_prev_r <= vs_i;
      if (vs_i && !vs_prev_r) begin
        row_r       <= 16'd0;
        line_base_r <= 32'd0;
      end else if (!de_i && de_prev_r) begin
        row_r <= row_r + 16'd1;
        if (row_in_win_s) line_base_r <= line_base_r + {16'd0, osd_h_i};
      end
    end
  end

  // Per-port window hit and bitmap pixel index (17/33-bit, no wrap).
  always_comb begin
    logic [16:0] x17;
    logic [16:0] xoff;
    logic [32:0] idx33;
    hit_s = {MAX_PORTS{1'b0}};
    x17   = 17'd0;
    xoff  = 17'd0;
    idx33 = 33'd0;
    for (int p = 0; p < MAX_PORTS; p++) begin
      x17      = {1'b0, col_r} + 17'(p);
      xoff     = x17 - {1'b0, osd_x_i};
      idx33    = {1'b0, line_base_r} + {16'd0, xoff};
      idx_s[p] = idx33[IDX_W-1:0];
      hit_s[p] = osd_enable_i && (p < int'(ports_eff_s)) && win_ok_s && row_in_win_s
                 && (x17 >= {1'b0, osd_x_i}) && (x17 < win_x_end_s)
                 && (idx33 < 33'(2 * OSD_MEM_WORDS));
    end
  end

  // Stages 1 and 2: hit/address, then aligned with the RAM read data.
  always_ff @(posedge vid_clk_i) begin
    if (vid_rst_i) begin
      hit1_r    <= {MAX_PORTS{1'b0}};
      hit2_r    <= {MAX_PORTS{1'b0}};
      transp1_r <= 1'b0;
      transp2_r <= 1'b0;
      r1_r      <= {PW{1'b0}};
      g1_r      <= {PW{1'b0}};
      b1_r      <= {PW{1'b0}};
      r2_r      <= {PW{1'b0}};
      g2_r      <= {PW{1'b0}};
      b2_r      <= {PW{1'b0}};
      for (int p = 0; p < MAX_PORTS; p++) idx1_r[p] <= {IDX_W{1'b0}};
    end else begin
      hit1_r    <= hit_s;
      hit2_r    <= hit1_r;
      transp1_r <= osd_transparent_i;
      transp2_r <= transp1_r;
      r1_r      <= r_i;
      g1_r      <= g_i;
      b1_r      <= b_i;
      r2_r      <= r1_r;
      g2_r      <= g1_r;
      b2_r      <= b1_r;
      for (int p = 0; p < MAX_PORTS; p++) idx1_r[p] <= idx_s[p];
    end
  end

  for (genvar gp = 0; gp < MAX_PORTS; gp++) begin : g_ram
    osd_pixel_ram #(
      .WORDS (OSD_MEM_WORDS),
      .IDX_W (IDX_W)
    ) u_ram (
      .clk   (vid_clk_i),
      .we    (wr_en_s),
      .waddr (osd_waddr_i[IDX_W-2:0]),
      .wdata (osd_wdata_i),
      .raddr (idx1_r[gp]),
      .rdata (ram_q_s[gp])
    );
  end

  // Per-port mix of bitmap and video.
  always_comb begin
    rgb888_t px;
    logic    keyed;
    mix_r_s = r2_r;
    mix_g_s = g2_r;
    mix_b_s = b2_r;
    px      = '{r: 8'd0, g: 8'd0, b: 8'd0};
    keyed   = 1'b0;
    for (int p = 0; p < MAX_PORTS; p++) begin
      px = rgb565_expand(ram_q_s[p]);
`ifdef OSD_COLORKEY_EN
      keyed = (ram_q_s[p] == 16'h0000);
`else
      keyed = 1'b0;
`endif
      if (hit2_r[p] && !keyed) begin
        if (transp2_r) begin
          mix_r_s[p*BPC +: BPC] = blend(to_bpc(px.r), r2_r[p*BPC +: BPC]);
          mix_g_s[p*BPC +: BPC] = blend(to_bpc(px.g), g2_r[p*BPC +: BPC]);
          mix_b_s[p*BPC +: BPC] = blend(to_bpc(px.b), b2_r[p*BPC +: BPC]);
        end else begin
          mix_r_s[p*BPC +: BPC] = to_bpc(px.r);
          mix_g_s[p*BPC +: BPC] = to_bpc(px.g);
          mix_b_s[p*BPC +: BPC] = to_bpc(px.b);
        end
      end else begin
        mix_r_s[p*BPC +: BPC] = r2_r[p*BPC +: BPC];
        mix_g_s[p*BPC +: BPC] = g2_r[p*BPC +: BPC];
        mix_b_s[p*BPC +: BPC] = b2_r[p*BPC +: BPC];
      end
    end
  end

  // Stage 3 output register and matching timing delay line.
  always_ff @(posedge vid_clk_i) begin
    if (vid_rst_i) begin
      r_o      <= {PW{1'b0}};
      g_o      <= {PW{1'b0}};
      b_o      <= {PW{1'b0}};
      vs_dly_r <= {LATENCY{1'b0}};
      hs_dly_r <= {LATENCY{1'b0}};
      de_dly_r <= {LATENCY{1'b0}};
    end else begin
      r_o      <= mix_r_s;
      g_o      <= mix_g_s;
      b_o      <= mix_b_s;
      vs_dly_r <= {vs_dly_r[LATENCY-2:0], vs_i};
      hs_dly_r <= {hs_dly_r[LATENCY-2:0], hs_i};
      de_dly_r <= {de_dly_r[LATENCY-2:0], de_i};
    end
  end

  assign vs_o = vs_dly_r[LATENCY-1];
  assign hs_o = hs_dly_r[LATENCY-1];
  assign de_o = de_dly_r[LATENCY-1];

endmodule

// File: tb/tb_osd_overlay.sv
// tb_osd_overlay -- directed self-checking bench for osd_overlay
// (MAX_PORTS=2, BPC=8). Expected values are hand-computed from the bitmap
// contents written by the bench.
module tb_osd_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs, hs, de;
  logic [15:0] r_in, g_in, b_in;
  logic        vs_o, hs_o, de_o;
  logic [15:0] r_o, g_o, b_o;
  logic        en, transp, wreq;
  logic [2:0]  ports;
  logic [15:0] ox, oy, oh, ov, waddr;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] cap_r [0:127];
  logic [15:0] cap_g [0:127];
  logic [15:0] cap_b [0:127];
  logic [2:0]  cap_t [0:127];
  logic [2:0]  drv_t [0:127];

`ifdef OSD_COLORKEY_EN
  localparam logic [7:0] KEY_EXP = 8'h0C;
`else
  localparam logic [7:0] KEY_EXP = 8'h00;
`endif

  always #5 clk = ~clk;

  osd_overlay dut (
    .vid_clk_i         (clk),
    .vid_rst_i         (rst),
    .vs_i              (vs),
    .hs_i              (hs),
    .de_i              (de),
    .r_i               (r_in),
    .g_i               (g_in),
    .b_i               (b_in),
    .vs_o              (vs_o),
    .hs_o              (hs_o),
    .de_o              (de_o),
    .r_o               (r_o),
    .g_o               (g_o),
    .b_o               (b_o),
    .osd_enable_i      (en),
    .osd_transparent_i (transp),
    .osd_ports_i       (ports),
    .osd_x_i           (ox),
    .osd_y_i           (oy),
    .osd_h_i           (oh),
    .osd_v_i           (ov),
    .osd_waddr_i       (waddr),
    .osd_wdata_i       (wdata),
    .osd_wreq_i        (wreq)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One video line: nde DE cycles then nblank blank cycles (hs on blank 1,
  // optional vs on blanks 2..3). Outputs are captured 3 cycles after input.
  task automatic run_line(input int nde, input int nblank, input logic vs_blank);
    int n;
    n = nde + nblank;
    for (int j = 0; j < n + 3; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        cap_r[j-3] = r_o;
        cap_g[j-3] = g_o;
        cap_b[j-3] = b_o;
        cap_t[j-3] = {vs_o, hs_o, de_o};
      end
      if (j < n) begin
        de = (j < nde);
        hs = (j == nde + 1);
        vs = vs_blank && (j >= nde + 2) && (j <= nde + 3);
        drv_t[j] = {vs, hs, de};
      end else begin
        de = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
      end
    end
  endtask

  task automatic vsync();
    @(negedge clk); vs = 1'b1;
    @(negedge clk); vs = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0;
    r_in = 16'h0C0C; g_in = 16'h0C0C; b_in = 16'h0C0C;
    en = 1'b0; transp = 1'b0; ports = 3'd2; wreq = 1'b0;
    ox = 16'd0; oy = 16'd0; oh = 16'd64; ov = 16'd64;
    waddr = 16'd0; wdata = 32'd0;

    // Reset with active inputs: outputs must stay 0.
    @(negedge clk); vs = 1'b1; hs = 1'b1; de = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_r", 32'(r_o), 32'h0);
    check_val("rst_g", 32'(g_o), 32'h0);
    check_val("rst_b", 32'(b_o), 32'h0);
    check_val("rst_t", 32'({vs_o, hs_o, de_o}), 32'h0);
    vs = 1'b0; hs = 1'b0; de = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Bitmap load, plus one out-of-range write that must be dropped.
    for (int n = 0; n <= 2000; n++) begin
      @(negedge clk);
      wreq = 1'b1; waddr = 16'(n); wdata = 32'h11001100 + 32'(n) * 32'h00010001;
    end
    @(negedge clk); waddr = 16'h1000; wdata = 32'hFFFFFFFF;
    @(negedge clk); wreq = 1'b0;

    // Pass-through with enable=0 inside the window.
    vsync();
    run_line(100, 4, 1'b1);
    for (int j = 0; j < 104; j++) check_val($sformatf("pt_timing[%0d]", j), 32'(cap_t[j]), 32'(drv_t[j]));
    check_val("pt_r0",  32'(cap_r[0]),  32'h0C0C);
    check_val("pt_g0",  32'(cap_g[0]),  32'h0C0C);
    check_val("pt_b0",  32'(cap_b[0]),  32'h0C0C);
    check_val("pt_r50", 32'(cap_r[50]), 32'h0C0C);

    // Replace mode, window at origin 64x64.
    en = 1'b1;
    vsync();
    run_line(100, 4, 1'b0);
    check_val("rep_r00",  32'(cap_r[0][7:0]),   32'h10);
    check_val("rep_g00",  32'(cap_g[0][7:0]),   32'h20);
    check_val("rep_b00",  32'(cap_b[0][7:0]),   32'h00);
    check_val("rep_r10",  32'(cap_r[0][15:8]),  32'h10);
    check_val("rep_b20",  32'(cap_b[1][7:0]),   32'h08);
    check_val("rep_b630", 32'(cap_b[31][15:8]), 32'hFF);
    check_val("rep_r640", 32'(cap_r[32][7:0]),  32'h0C);
    check_val("rep_g640", 32'(cap_g[32][7:0]),  32'h0C);
    run_line(100, 4, 1'b0);
    check_val("rep_g01",  32'(cap_g[0][7:0]),   32'h24);

    // Ports above MAX_PORTS clamp to 2.
    ports = 3'd7;
    vsync();
    run_line(100, 4, 1'b0);
    check_val("clamp_b30",  32'(cap_b[1][15:8]), 32'h08);
    check_val("clamp_r640", 32'(cap_r[32][7:0]), 32'h0C);
    ports = 3'd2;

    // Blend mode.
    transp = 1'b1;
    vsync();
    run_line(100, 4, 1'b0);
    check_val("bl_r00",  32'(cap_r[0][7:0]),  32'h0E);
    check_val("bl_g00",  32'(cap_g[0][7:0]),  32'h16);
    check_val("bl_b00",  32'(cap_b[0][7:0]),  32'h06);
    check_val("bl_r640", 32'(cap_r[32][7:0]), 32'h0C);
    transp = 1'b0;

    // Window offset X=10, Y=5.
    ox = 16'd10; oy = 16'd5;
    vsync();
    for (int row = 0; row < 70; row++) begin
      run_line(20, 4, 1'b0);
      if (row == 4) check_val("off_r10_4", 32'(cap_r[5][7:0]), 32'h0C);
      if (row == 5) begin
        check_val("off_r9_5",  32'(cap_r[4][15:8]), 32'h0C);
        check_val("off_r10_5", 32'(cap_r[5][7:0]),  32'h10);
        check_val("off_g10_5", 32'(cap_g[5][7:0]),  32'h20);
      end
      if (row == 36) check_val("off_g10_36", 32'(cap_g[5][7:0]), 32'h9E);
      if (row == 69) check_val("off_r10_69", 32'(cap_r[5][7:0]), 32'h0C);
    end
    ox = 16'd0; oy = 16'd0;

    // Colour key: bitmap word 0 cleared.
    @(negedge clk); wreq = 1'b1; waddr = 16'd0; wdata = 32'h00000000;
    @(negedge clk); wreq = 1'b0;
    vsync();
    run_line(100, 4, 1'b0);
    check_val("key_r00", 32'(cap_r[0][7:0]), 32'(KEY_EXP));
    check_val("key_g00", 32'(cap_g[0][7:0]), 32'(KEY_EXP));
    check_val("key_b20", 32'(cap_b[1][7:0]), 32'h08);

    // One port per clock: upper port passes video through.
    ports = 3'd1;
    vsync();
    run_line(70, 4, 1'b0);
    check_val("p1_b20",   32'(cap_b[2][7:0]),  32'h08);
    check_val("p1_g20",   32'(cap_g[2][7:0]),  32'h20);
    check_val("p1_hi_r",  32'(cap_r[2][15:8]), 32'h0C);
    check_val("p1_hi_b",  32'(cap_b[2][15:8]), 32'h0C);
    check_val("p1_r640",  32'(cap_r[64][7:0]), 32'h0C);

    // Reset held 5 clocks in the middle of an active line.
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); de = 1'b1;
    end
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val($sformatf("mrst_r[%0d]", k), 32'(r_o), 32'h0);
      check_val($sformatf("mrst_t[%0d]", k), 32'({vs_o, hs_o, de_o}), 32'h0);
    end
    rst = 1'b0; de = 1'b0;
    repeat (6) @(negedge clk);
    run_line(70, 4, 1'b0);
    check_val("mrst_g20", 32'(cap_g[2][7:0]), 32'h20);
    check_val("mrst_b20", 32'(cap_b[2][7:0]), 32'h08);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
